// File: rtl/risc_pkg.sv
// Shared widths, mux-D' select encodings and stall-FSM state type for the RISC pipeline.
package risc_pkg;

    localparam int RISC_DATA_W = 32;
    localparam int RISC_AW     = 5;
    localparam int RISC_CNT_W  = 16;

    typedef enum logic [1:0] {
        MD_FUNC  = 2'b00,
        MD_DATA  = 2'b01,
        MD_NXORV = 2'b10
    } md_sel_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } stall_state_t;

endpackage

// File: rtl/regfile_2r1w.sv
// 2**AW x DATA_W register file: two async read ports, one sync write port, R0 hardwired to zero.
module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int AW     = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [AW-1:0]     i_wa,
    input  logic [DATA_W-1:0] i_wd,
    input  logic [AW-1:0]     i_ra_a,
    input  logic [AW-1:0]     i_ra_b,
    output logic [DATA_W-1:0] o_rd_a,
    output logic [DATA_W-1:0] o_rd_b
);

    logic [DATA_W-1:0] r_mem [2**AW];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem <= '{default: '0};
        end else if (i_we && (i_wa != '0)) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_rd_a = (i_ra_a == '0) ? '0 : r_mem[i_ra_a];
    assign o_rd_b = (i_ra_b == '0) ? '0 : r_mem[i_ra_b];

endmodule

// File: rtl/writeback_regfile.sv
// WB pipeline register + register file with write-through reads, EX hazard stall and counters.
// Optional macro FORWARD_EN: adds the EX->DOF bypass and ties STALL low.
module writeback_regfile
    import risc_pkg::*;
#(
    parameter int DATA_W = RISC_DATA_W,
    parameter int AW     = RISC_AW,
    parameter int CNT_W  = RISC_CNT_W
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              RW_1,
    input  logic [AW-1:0]     DA_1,
    input  logic [DATA_W-1:0] Bus_Dprime,
    input  logic [AW-1:0]     AA,
    input  logic [AW-1:0]     BA,
    output logic [DATA_W-1:0] A_DATA,
    output logic [DATA_W-1:0] B_DATA,
    output logic              STALL,
    output logic              RW_2,
    output logic [AW-1:0]     DA_2,
    output logic [DATA_W-1:0] D_2,
    output logic [CNT_W-1:0]  STALL_CNT,
    output logic [CNT_W-1:0]  RETIRE_CNT
);

    logic              r_rw2;
    logic [AW-1:0]     r_da2;
    logic [DATA_W-1:0] r_d2;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_retire_cnt;
    stall_state_t      r_state;
    stall_state_t      w_state_nxt;

    logic                   w_commit;
    logic                   w_stall;
    logic [DATA_W-1:0]      w_rf_a;
    logic [DATA_W-1:0]      w_rf_b;
    logic [1:0][AW-1:0]     w_ra;
    logic [1:0][DATA_W-1:0] w_rf;
    logic [1:0][DATA_W-1:0] w_rd;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_rw2 <= 1'b0;
            r_da2 <= '0;
            r_d2  <= '0;
        end else begin
            r_rw2 <= RW_1;
            r_da2 <= DA_1;
            r_d2  <= Bus_Dprime;
        end
    end

    assign w_commit = r_rw2 && (r_da2 != '0);

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_rf (
        .i_clk  (CLK),
        .i_rst  (reset),
        .i_we   (w_commit),
        .i_wa   (r_da2),
        .i_wd   (r_d2),
        .i_ra_a (AA),
        .i_ra_b (BA),
        .o_rd_a (w_rf_a),
        .o_rd_b (w_rf_b)
    );

    assign w_ra = {BA, AA};
    assign w_rf = {w_rf_b, w_rf_a};

    // Read priority: R0, EX bypass (optional), WB write-through, array. Reset forces zero at once.
    always_comb begin
        w_rd = '0;
        for (int p = 0; p < 2; p++) begin
            w_rd[p] = w_rf[p];
            if (reset || (w_ra[p] == '0)) begin
                w_rd[p] = '0;
            end
`ifdef FORWARD_EN
            else if (RW_1 && (DA_1 == w_ra[p])) begin
                w_rd[p] = Bus_Dprime;
            end
`endif
            else if (r_rw2 && (r_da2 == w_ra[p])) begin
                w_rd[p] = r_d2;
            end
        end
    end

    assign A_DATA = w_rd[0];
    assign B_DATA = w_rd[1];

`ifdef FORWARD_EN
    assign w_stall = 1'b0;
`else
    // Without a bypass the EX result is one edge away from write-through; hold DOF for it.
    assign w_stall = !reset && RW_1 && (DA_1 != '0) && ((DA_1 == AA) || (DA_1 == BA));
`endif

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_stall)  w_state_nxt = HOLD;
            HOLD:    if (!w_stall) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_commit)                       r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    assign STALL      = w_stall;
    assign RW_2       = r_rw2;
    assign DA_2       = r_da2;
    assign D_2        = r_d2;
    assign STALL_CNT  = r_stall_cnt;
    assign RETIRE_CNT = r_retire_cnt;

endmodule
